// File: rtl/boxmuller_pkg.sv
// Shared types and constants for the Box-Muller trig sequencer.
package boxmuller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Uniform sample field layout as seen by the trig unit address bus
    localparam int COS_IDX_MSB = 31;
    localparam int COS_IDX_LSB = 22;
    localparam int SIN_IDX_MSB = 15;
    localparam int SIN_IDX_LSB = 6;
    localparam int FRAC_W      = 6;

    localparam int TRIG_W = 16;

endpackage

// File: rtl/boxmuller_out_reg.sv
// One-deep valid/ready holding register for a sin/cos pair.
// A load in the same cycle as a drain replaces the pair and keeps valid high.
import boxmuller_pkg::*;

module boxmuller_out_reg (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [TRIG_W-1:0] i_sin,
    input  logic [TRIG_W-1:0] i_cos,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [TRIG_W-1:0] o_sin,
    output logic [TRIG_W-1:0] o_cos
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_sin   <= '0;
            o_cos   <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_sin   <= i_sin;
            o_cos   <= i_cos;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/boxmuller_trig_sequencer.sv
// Feeds uniform samples to the trig lookup unit one at a time, owning its clear,
// and captures each sin/cos result into a valid/ready output register.
import boxmuller_pkg::*;

module boxmuller_trig_sequencer #(
    parameter int CLEAR_CYCLES = 3,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              u_valid,
    input  logic [31:0]       u_data,
    output logic              u_ready,
    output logic [31:0]       trig_address,
    output logic              trig_clear,
    input  logic              trig_done,
    input  logic [TRIG_W-1:0] trig_sin,
    input  logic [TRIG_W-1:0] trig_cos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TRIG_W-1:0] out_sin,
    output logic [TRIG_W-1:0] out_cos,
    output logic              busy,
    output logic              timeout_err,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  sample_count
);

    state_t     r_state;
    logic [3:0] r_clr_cnt;
    logic [7:0] r_to_cnt;
    logic       w_can_load;
    logic       w_load;

    assign w_can_load = !out_valid || out_ready;
    assign w_load     = (r_state == WAIT_DONE) && trig_done && w_can_load;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clr_cnt    <= '0;
            r_to_cnt     <= '0;
            u_ready      <= 1'b1;
            trig_address <= '0;
            trig_clear   <= 1'b1;
            timeout_err  <= 1'b0;
            sample_count <= '0;
        end else begin
            // A timeout below overrides this clear in the same cycle
            if (clr_err)
                timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    u_ready    <= 1'b1;
                    trig_clear <= 1'b1;
                    if (u_valid && u_ready) begin
                        trig_address <= u_data;
                        r_clr_cnt    <= 4'(CLEAR_CYCLES - 1);
                        u_ready      <= 1'b0;
                        r_state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (r_clr_cnt == 4'd0) begin
                        trig_clear <= 1'b0;
                        r_to_cnt   <= '0;
                        r_state    <= WAIT_DONE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt - 4'd1;
                    end
                end
                WAIT_DONE: begin
                    // Done is sticky in the unit, so a full output just stalls here
                    if (trig_done) begin
                        if (w_can_load) begin
                            sample_count <= sample_count + CNT_W'(1);
                            trig_clear   <= 1'b1;
                            u_ready      <= 1'b1;
                            r_state      <= IDLE;
                        end
                    end else if (r_to_cnt == 8'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        trig_clear  <= 1'b1;
                        u_ready     <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: begin
                    trig_clear <= 1'b1;
                    u_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    boxmuller_out_reg u_out_reg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_sin   (trig_sin),
        .i_cos   (trig_cos),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_sin   (out_sin),
        .o_cos   (out_cos)
    );

endmodule

// File: tb/tb_boxmuller_trig_sequencer.sv
// Directed bench for boxmuller_trig_sequencer with a behavioural trig unit model.
// Counter width is reduced to 8 so the wrap case stays short.
module tb_boxmuller_trig_sequencer;

    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        u_valid = 1'b0;
    logic [31:0] u_data = '0;
    logic        u_ready;
    logic [31:0] trig_address;
    logic        trig_clear;
    logic        trig_done;
    logic [15:0] trig_sin = '0;
    logic [15:0] trig_cos = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sin;
    logic [15:0] out_cos;
    logic        busy;
    logic        timeout_err;
    logic        clr_err = 1'b0;
    logic [CNT_W-1:0] sample_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    logic model_en = 1'b1;
    int   model_lat = 4;
    int   m_cnt;

    always #5 clk = ~clk;

    boxmuller_trig_sequencer #(.CLEAR_CYCLES(3), .TIMEOUT(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .u_valid(u_valid), .u_data(u_data), .u_ready(u_ready),
        .trig_address(trig_address), .trig_clear(trig_clear), .trig_done(trig_done),
        .trig_sin(trig_sin), .trig_cos(trig_cos), .out_valid(out_valid),
        .out_ready(out_ready), .out_sin(out_sin), .out_cos(out_cos), .busy(busy),
        .timeout_err(timeout_err), .clr_err(clr_err), .sample_count(sample_count)
    );

    // Trig unit model: done rises model_lat cycles after clear drops, sticky until clear
    always @(posedge clk or posedge reset) begin
        if (reset || trig_clear) begin
            trig_done <= 1'b0;
            m_cnt     <= 0;
        end else if (model_en && !trig_done) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 >= model_lat)
                trig_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        while (!u_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_ready_wait", {31'b0, u_ready}, 32'd1);
        u_valid = 1'b1;
        u_data  = d;
        @(negedge clk);
        u_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("out_valid_wait", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_clear_low();
        int n = 0;
        while (trig_clear && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("clear_low_wait", {31'b0, trig_clear}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] acc;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_u_ready", {31'b0, u_ready}, 32'd1);
        chk("rst_clear", {31'b0, trig_clear}, 32'd1);
        chk("rst_addr", trig_address, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {out_sin, out_cos}, 32'd0);
        chk("rst_err", {31'b0, timeout_err}, 32'd0);
        chk("rst_count", {24'b0, sample_count}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single sample
        trig_sin = 16'h1234; trig_cos = 16'h5678; model_lat = 4; out_ready = 1'b1;
        send(32'h0040_0080);
        chk("single_addr", trig_address, 32'h0040_0080);
        chk("single_busy", {31'b0, busy}, 32'd1);
        chk("single_u_ready", {31'b0, u_ready}, 32'd0);
        cyc = 0;
        while (trig_clear && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("single_clear_cycles", cyc, 32'd3);
        wait_out();
        exp_cnt++;
        chk("single_data", {out_sin, out_cos}, 32'h1234_5678);
        @(negedge clk);
        chk("single_valid_pulse", {31'b0, out_valid}, 32'd0);
        chk("single_count", {24'b0, sample_count}, exp_cnt);

        // Backpressure: second pair waits with done held, then swaps in on drain
        out_ready = 1'b0;
        trig_sin = 16'h1111; trig_cos = 16'h2222;
        send(32'h0000_0001);
        wait_out();
        exp_cnt++;
        chk("bp_first", {out_sin, out_cos}, 32'h1111_2222);
        trig_sin = 16'h3333; trig_cos = 16'h4444;
        send(32'h0000_0002);
        repeat (80) @(negedge clk);
        chk("bp_done_held", {31'b0, trig_done}, 32'd1);
        chk("bp_busy", {31'b0, busy}, 32'd1);
        chk("bp_no_timeout", {31'b0, timeout_err}, 32'd0);
        chk("bp_u_ready", {31'b0, u_ready}, 32'd0);
        chk("bp_first_stable", {out_sin, out_cos}, 32'h1111_2222);
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("bp_swap_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_swap_data", {out_sin, out_cos}, 32'h3333_4444);
        chk("bp_swap_idle", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("bp_drained", {31'b0, out_valid}, 32'd0);
        chk("bp_count", {24'b0, sample_count}, exp_cnt);

        // Timeout
        model_en = 1'b0;
        send(32'h0000_0003);
        wait_clear_low();
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        chk("to_wait_cycles", cyc, 32'd64);
        chk("to_err", {31'b0, timeout_err}, 32'd1);
        chk("to_busy", {31'b0, busy}, 32'd0);
        chk("to_no_out", {31'b0, out_valid}, 32'd0);
        chk("to_count", {24'b0, sample_count}, exp_cnt);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("to_clr_err", {31'b0, timeout_err}, 32'd0);

        // Address stability while busy
        model_en = 1'b1;
        trig_sin = 16'h0A0A; trig_cos = 16'h0B0B;
        send(32'hCAFE_0040);
        acc = 32'hCAFE_0040;
        u_valid = 1'b1;
        cyc = 0;
        while (busy && cyc < 100) begin
            chk("addr_hold", trig_address, acc);
            u_data = ~u_data ^ 32'(cyc);
            cyc++;
            @(negedge clk);
        end
        u_valid = 1'b0;
        exp_cnt++;
        chk("addr_result", {out_sin, out_cos}, 32'h0A0A_0B0B);
        @(negedge clk);
        chk("addr_count", {24'b0, sample_count}, exp_cnt);

        // Asynchronous reset during WAIT_DONE
        model_en = 1'b0;
        send(32'h0000_0055);
        wait_clear_low();
        #2 reset = 1'b1;
        #1;
        chk("ar_clear", {31'b0, trig_clear}, 32'd1);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_u_ready", {31'b0, u_ready}, 32'd1);
        chk("ar_addr", trig_address, 32'd0);
        chk("ar_count", {24'b0, sample_count}, 32'd0);
        chk("ar_out", {15'b0, out_valid, out_sin}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        model_en = 1'b1;
        trig_sin = 16'h7777; trig_cos = 16'h8888;
        @(negedge clk);
        send(32'h0000_0066);
        wait_out();
        exp_cnt++;
        chk("ar_after_data", {out_sin, out_cos}, 32'h7777_8888);
        @(negedge clk);
        chk("ar_after_count", {24'b0, sample_count}, exp_cnt);

        // Counter wrap with a fast unit
        model_lat = 1;
        for (int i = 0; i < 255; i++) begin
            send(32'(i));
            wait_out();
            exp_cnt++;
            if (i == 253) begin
                @(negedge clk);
                chk("wrap_ff", {24'b0, sample_count}, 32'h0000_00FF);
            end
        end
        @(negedge clk);
        chk("wrap_zero", {24'b0, sample_count}, 32'(exp_cnt % 256));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
